// File: rtl/serial_sub2.sv
// serial_sub2: multi-cycle subtractor computing a - b - bin two bits per cycle.
// Operands are latched on an accepted start. The borrow ripples through
// WIDTH/2 slices, LSB slice first. A one-cycle done pulse marks a valid
// diff/bout/ovf, and those outputs then hold until the next accepted start.
module serial_sub2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int SLICES = WIDTH / 2;
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W:0]   w_base;
  logic [1:0]       w_a2;
  logic [1:0]       w_b2;
  logic [2:0]       w_res;
  logic             w_last;
  logic             w_accept;

  // Two-bit ripple-borrow subtract: returns {borrow_out, d1, d0}.
  function automatic logic [2:0] sub2_slice(input logic [1:0] x,
                                            input logic [1:0] y,
                                            input logic       bi);
    logic d0, d1, b1, b2;
    d0 = x[0] ^ y[0] ^ bi;
    b1 = (~x[0] & y[0]) | (~(x[0] ^ y[0]) & bi);
    d1 = x[1] ^ y[1] ^ b1;
    b2 = (~x[1] & y[1]) | (~(x[1] ^ y[1]) & b1);
    return {b2, d1, d0};
  endfunction

  // Bit offset of the current slice is twice the slice counter.
  assign w_base   = {r_cnt, 1'b0};
  assign w_a2     = r_a[w_base +: 2];
  assign w_b2     = r_b[w_base +: 2];
  assign w_res    = sub2_slice(w_a2, w_b2, r_borrow);
  assign w_last   = (r_cnt == LAST);
  assign w_accept = rst_n && (r_state == S_IDLE) && start;

  // Operand capture at an accepted start; operands need no reset value.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // Control FSM and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_borrow <= bin;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_diff[w_base +: 2] <= w_res[1:0];
          r_borrow            <= w_res[2];
          if (w_last) begin
            // Last slice: w_res[1] is the final diff MSB.
            r_bout  <= w_res[2];
            r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_res[1] != r_a[WIDTH-1]);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_serial_sub2.sv
// Directed bench for serial_sub2 (WIDTH=8) with hand-computed expectations.
module tb_serial_sub2;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  serial_sub2 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Present operands with start in one cycle; returns just after the accept edge,
  // then scrambles the inputs so a late change would corrupt the result.
  task automatic launch(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb;
    bin   = tbin;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~ta;
    b     = ~tb;
    bin   = ~tbin;
  endtask

  // Wait (bounded) for done, sampling on falling edges. lat counts rising
  // edges since the accept edge; stamp is the cycle counter at detection.
  task automatic wait_done(output int lat, output bit seen, output int stamp);
    lat   = 0;
    seen  = 1'b0;
    stamp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen  = 1'b1;
        stamp = cyc;
        break;
      end
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                    input logic tbin, input logic [7:0] ed, input logic eb, input logic eo);
    int  lat;
    bit  seen;
    int  stamp;
    launch(ta, tb, tbin);
    wait_done(lat, seen, stamp);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  int  lat1, lat2, st1, st2, pulses;
  bit  seen1, seen2;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;

    // Basic and boundary vectors.
    op("v5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
    // Results hold after done until the next accepted start.
    repeat (3) @(negedge clk);
    check("hold_diff", 32'(diff), 32'h1E);
    check("hold_busy", 32'(busy), 32'd0);
    op("v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op("vff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op("v7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Start during RUN is ignored: one done, original result.
    launch(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    bin   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat1, seen1, st1);
    check("ign_done_seen", 32'(seen1), 32'd1);
    check("ign_diff", 32'(diff), 32'h0F);
    @(negedge clk);
    check("ign_busy_after", 32'(busy), 32'd0);
    check("ign_done_after", 32'(done), 32'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("ign_no_extra_done", 32'(pulses), 32'd0);
    check("ign_diff_kept", 32'(diff), 32'h0F);

    // Reset abort after the second RUN slice.
    launch(8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    op("after_abort", 8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

    // Back-to-back: second start in the IDLE cycle right after done.
    launch(8'h20, 8'h05, 1'b0);
    wait_done(lat1, seen1, st1);
    check("b2b1_seen", 32'(seen1), 32'd1);
    check("b2b1_diff", 32'(diff), 32'h1B);
    check("b2b1_bout", 32'(bout), 32'd0);
    launch(8'h05, 8'h20, 1'b1);
    wait_done(lat2, seen2, st2);
    check("b2b2_seen", 32'(seen2), 32'd1);
    check("b2b2_diff", 32'(diff), 32'hE4);
    check("b2b2_bout", 32'(bout), 32'd1);
    check("b2b2_ovf",  32'(ovf),  32'd0);
    check("b2b_gap_cycles_between", 32'(st2 - st1 - 1), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_sub2.md
SERIAL_SUB2 -- requirements
Module: serial_sub2

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; even, >= 2.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1: request pulse; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH: minuend; captured at accepted start.
REQ-006 SHALL have port b  input  WIDTH: subtrahend; captured at accepted start.
REQ-007 SHALL have port bin  input  1: borrow-in; captured at accepted start.
REQ-008 SHALL have port diff  output  WIDTH: result a - b - bin, modulo 2^WIDTH.
REQ-009 SHALL have port bout  output  1: borrow-out; 1 when a < b + bin (unsigned).
REQ-010 SHALL have port ovf  output  1: two's-complement signed overflow of the subtraction.
REQ-011 SHALL have port busy  output  1: high in RUN and DONE.
REQ-012 SHALL have port done  output  1: one-cycle pulse; diff/bout/ovf are valid.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at an edge SHALL: latch a, b; load borrow register with bin; clear slice counter; clear diff, bout, ovf; go to RUN.
REQ-015 IDLE with start=0 SHALL hold all registers.
REQ-016 RUN SHALL process one 2-bit slice per cycle, LSB slice first, for WIDTH/2 cycles.
REQ-017 Each slice SHALL compute {a_hi,a_lo} - {b_hi,b_lo} - borrow as a 2-bit ripple: 2 result bits into diff at slice position; new borrow into borrow register.
REQ-018 On the last RUN slice, the edge SHALL load bout with final borrow, compute ovf = (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]), and go to DONE.
REQ-019 DONE SHALL assert done for exactly one cycle (Moore output); the next edge returns to IDLE.
REQ-020 Latency: with start accepted at edge E0, done SHALL be high during the cycle after edge E(WIDTH/2) (cycle after E4 for WIDTH=8).
REQ-021 start in RUN or DONE SHALL be ignored; the operation in flight is not disturbed and no request is queued.
REQ-022 diff, bout, ovf SHALL hold their values from DONE until the next accepted start.
REQ-023 Changes on a, b, bin after acceptance SHALL NOT affect the result.
REQ-024 Back-to-back: start high in the IDLE cycle right after DONE SHALL be accepted; no minimum gap beyond that.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, with diff=0, bout=0, ovf=0, busy=0, done=0, counter=0, borrow=0.
REQ-026 Reset SHALL have priority over start and SHALL abort an operation in flight; no done pulse follows.
REQ-027 rst_n SHALL have no effect between clock edges (synchronous only).

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, bin=0, start pulse -> done exactly 4 cycles after accept edge; diff=0x1E, bout=0, ovf=0.
REQ-029 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0. Then a=0xFF, b=0xFF, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-030 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF, bin=0 -> diff=0x80, bout=1, ovf=1.
REQ-031 Start 0x10-0x01, then pulse start with a=0xAA, b=0x55 during RUN -> single done; diff=0x0F; busy low the cycle after done.
REQ-032 Hold rst_n=0 at the edge after the second RUN slice -> next cycle busy=0, diff=0, bout=0, done never pulses. A fresh start then completes normally.
REQ-033 Two operations with start asserted in the IDLE cycle right after done -> both done pulses appear 5 cycles apart with correct results.
